// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit: state codes,
// opcodes, ALU/mux select encodings and the per-state Moore control decode.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST      = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_MEM_ADDR = 4'd3,
        S_MEM_RD   = 4'd4,
        S_MEM_WB   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_EXEC     = 4'd7,
        S_R_WB     = 4'd8,
        S_BRANCH   = 4'd9,
        S_JUMP     = 4'd10,
        S_ADDI_EX  = 4'd11,
        S_ADDI_WB  = 4'd12,
        S_HALT     = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;

    localparam logic [1:0] SRCB_RT     = 2'b00;
    localparam logic [1:0] SRCB_FOUR   = 2'b01;
    localparam logic [1:0] SRCB_IMM    = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

    function automatic logic op_legal(logic [5:0] op);
        return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
               (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
    endfunction

    function automatic logic is_mem_wait(state_t s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

    // FETCH's pc_write/ir_write depend on mem_ready and are added at the top level.
    function automatic ctrl_t ctrl_decode(state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:    begin c.mem_read = 1'b1; c.alu_src_b = SRCB_FOUR; end
            S_DECODE:   c.alu_src_b = SRCB_IMM_SH;
            S_MEM_ADDR: begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_MEM_RD:   begin c.mem_read = 1'b1; c.i_or_d = 1'b1; end
            S_MEM_WB:   begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_MEM_WR:   begin c.mem_write = 1'b1; c.i_or_d = 1'b1; end
            S_EXEC:     begin c.alu_src_a = 1'b1; c.alu_op = ALUOP_FUNCT; end
            S_R_WB:     begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BRANCH:   begin
                c.alu_src_a = 1'b1; c.alu_op = ALUOP_SUB;
                c.pc_write_cond = 1'b1; c.pc_source = PCSRC_ALUOUT;
            end
            S_JUMP:     begin c.pc_write = 1'b1; c.pc_source = PCSRC_JUMP; end
            S_ADDI_EX:  begin c.alu_src_a = 1'b1; c.alu_src_b = SRCB_IMM; end
            S_ADDI_WB:  c.reg_write = 1'b1;
            default:    c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Datapath <-> controller bundle: status inputs to the FSM and every select/enable it drives.
interface multicycle_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source
    );
endinterface

// File: rtl/mc_mem_timer.sv
// Memory-wait watchdog: counts stalled cycles in a memory state and raises a sticky
// trap flag when the wait reaches MEM_TIMEOUT cycles without mem_ready.
module mc_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic enter_i,
    input  logic active_i,
    input  logic mem_ready_i,
    output logic hit_o,
    output logic timeout_o
);
    localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

    logic [TW-1:0] cnt_q;
    logic          flag_q;

    // A ready on the last allowed cycle wins over the trap.
    assign hit_o     = active_i && !mem_ready_i && (cnt_q == TW'(MEM_TIMEOUT - 1));
    assign timeout_o = flag_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            if (enter_i)
                cnt_q <= '0;
            else if (active_i && !mem_ready_i)
                cnt_q <= cnt_q + TW'(1);
            if (hit_o)
                flag_q <= 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-wait watchdog.
// Optional performance counters are built when MULTICYCLE_PERF_CNT_EN is defined.
module multicycle_control
    import mc_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus,
    output logic [3:0]           state,
    output logic                 illegal_op,
    output logic                 mem_timeout,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     instr_count
);
    state_t state_q, state_d;
    ctrl_t  ctl_q;
    logic   timeout_hit;
    logic   in_fetch;

    mc_mem_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .enter_i    (is_mem_wait(state_d) && (state_d != state_q)),
        .active_i   (is_mem_wait(state_q)),
        .mem_ready_i(bus.mem_ready),
        .hit_o      (timeout_hit),
        .timeout_o  (mem_timeout)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:      state_d = S_FETCH;
            S_FETCH:    if (bus.mem_ready) state_d = S_DECODE;
                        else if (timeout_hit) state_d = S_HALT;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEM_ADDR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
                    OP_ADDI:      state_d = S_ADDI_EX;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: state_d = (bus.opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (bus.mem_ready) state_d = S_MEM_WB;
                        else if (timeout_hit) state_d = S_HALT;
            S_MEM_WR:   if (bus.mem_ready) state_d = S_FETCH;
                        else if (timeout_hit) state_d = S_HALT;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            S_EXEC:     state_d = S_R_WB;
            S_ADDI_EX:  state_d = S_ADDI_WB;
            S_HALT:     state_d = S_HALT;
            default:    state_d = S_RST;
        endcase
    end

    // Control outputs are registered from the next state, so they line up with state_q.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_RST;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ctl_q   <= ctrl_decode(state_d);
        end
    end

    assign in_fetch          = (state_q == S_FETCH);
    assign state             = state_q;
    assign illegal_op        = (state_q == S_DECODE) && !op_legal(bus.opcode);
    assign bus.pc_write      = ctl_q.pc_write | (in_fetch & bus.mem_ready);
    assign bus.ir_write      = in_fetch & bus.mem_ready;
    assign bus.pc_write_cond = ctl_q.pc_write_cond;
    assign bus.i_or_d        = ctl_q.i_or_d;
    assign bus.mem_read      = ctl_q.mem_read;
    assign bus.mem_write     = ctl_q.mem_write;
    assign bus.mem_to_reg    = ctl_q.mem_to_reg;
    assign bus.reg_dst       = ctl_q.reg_dst;
    assign bus.reg_write     = ctl_q.reg_write;
    assign bus.alu_src_a     = ctl_q.alu_src_a;
    assign bus.alu_src_b     = ctl_q.alu_src_b;
    assign bus.alu_op        = ctl_q.alu_op;
    assign bus.pc_source     = ctl_q.pc_source;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cyc_q, ins_q;

    // DECODE -> FETCH only happens for an illegal opcode, which is not counted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cyc_q <= '0;
            ins_q <= '0;
        end else begin
            if (state_q != S_RST && state_q != S_HALT)
                cyc_q <= cyc_q + CNT_W'(1);
            if (state_d == S_FETCH && !in_fetch && state_q != S_RST && state_q != S_DECODE)
                ins_q <= ins_q + CNT_W'(1);
        end
    end

    assign cycle_count = cyc_q;
    assign instr_count = ins_q;
`else
    assign cycle_count = '0;
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction cycle scripts built
// from the instruction-class timing rules, directed corner cases plus a random stream.
module tb_multicycle_control;
    localparam int TO = 16;

    localparam logic [3:0] RST = 0, FETCH = 1, DECODE = 2, MADDR = 3, MRD = 4, MWB = 5,
                           MWR = 6, EXEC = 7, RWB = 8, BR = 9, JMP = 10, AEX = 11,
                           AWB = 12, HALT = 13;
    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011,
                           BEQ = 6'b000100, J = 6'b000010, ADDI = 6'b001000;

    typedef struct {
        logic [3:0] st;
        bit         rdy;
        logic [5:0] op;
        bit         last_legal;
        bit         trap;
    } rec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [3:0]  state;
    logic        illegal_op, mem_timeout;
    logic [31:0] cycle_count, instr_count;

    int checks = 0;
    int errors = 0;
    rec_t q[$];
    logic [31:0] exp_cyc, exp_ins;
    bit exp_to;

    multicycle_control_if bus();

    multicycle_control #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .state      (state),
        .illegal_op (illegal_op),
        .mem_timeout(mem_timeout),
        .cycle_count(cycle_count),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    function automatic bit legal(logic [5:0] op);
        return op == RT || op == LW || op == SW || op == BEQ || op == J || op == ADDI;
    endfunction

    // {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write, mem_to_reg,
    //  reg_dst, reg_write, alu_src_a, alu_src_b[2], alu_op[3], pc_source[2], illegal_op}
    function automatic logic [17:0] exp_out(logic [3:0] st, bit rdy, logic [5:0] op);
        logic pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill;
        logic [1:0] sb, ps;
        logic [2:0] ao;
        {pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, ill} = '0;
        sb = 2'b00; ps = 2'b00; ao = 3'b000;
        case (st)
            FETCH:  begin mr = 1; sb = 2'b01; pcw = rdy; irw = rdy; end
            DECODE: begin sb = 2'b11; ill = !legal(op); end
            MADDR:  begin sa = 1; sb = 2'b10; end
            MRD:    begin mr = 1; iod = 1; end
            MWB:    begin rw = 1; m2r = 1; end
            MWR:    begin mw = 1; iod = 1; end
            EXEC:   begin sa = 1; ao = 3'b010; end
            RWB:    begin rw = 1; rd = 1; end
            BR:     begin sa = 1; ao = 3'b001; pwc = 1; ps = 2'b01; end
            JMP:    begin pcw = 1; ps = 2'b10; end
            AEX:    begin sa = 1; sb = 2'b10; end
            AWB:    rw = 1;
            default: ;
        endcase
        return {pcw, pwc, iod, mr, mw, irw, m2r, rd, rw, sa, sb, ao, ps, ill};
    endfunction

    function automatic logic [17:0] obs_out();
        return {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read, bus.mem_write,
                bus.ir_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                bus.alu_src_b, bus.alu_op, bus.pc_source, illegal_op};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Opcode is only meaningful in DECODE/MEM_ADDR; elsewhere it is scrambled.
    task automatic push(input logic [3:0] st, input bit rdy, input logic [5:0] op, input bit trap);
        rec_t r;
        r.st = st;
        r.rdy = rdy;
        r.op = (st == DECODE || st == MADDR) ? op : 6'($urandom_range(0, 63));
        r.last_legal = 0;
        r.trap = trap;
        q.push_back(r);
    endtask

    task automatic push_wait(input logic [3:0] st, input int w, input logic [5:0] op, output bit trapped);
        if (w >= TO) begin
            for (int i = 0; i < TO; i++) push(st, 0, op, i == TO - 1);
            repeat (3) push(HALT, 1'($urandom_range(0, 1)), op, 0);
            trapped = 1;
        end else begin
            for (int i = 0; i < w; i++) push(st, 0, op, 0);
            push(st, 1, op, 0);
            trapped = 0;
        end
    endtask

    task automatic add_instr(input logic [5:0] op, input int wf, input int wm);
        bit t;
        push_wait(FETCH, wf, op, t);
        if (t) return;
        push(DECODE, 1'($urandom_range(0, 1)), op, 0);
        case (op)
            RT:   begin push(EXEC, 1'($urandom_range(0, 1)), op, 0); push(RWB, 1'($urandom_range(0, 1)), op, 0); end
            LW:   begin
                push(MADDR, 1'($urandom_range(0, 1)), op, 0);
                push_wait(MRD, wm, op, t);
                if (!t) push(MWB, 1'($urandom_range(0, 1)), op, 0);
            end
            SW:   begin push(MADDR, 1'($urandom_range(0, 1)), op, 0); push_wait(MWR, wm, op, t); end
            BEQ:  push(BR, 1'($urandom_range(0, 1)), op, 0);
            J:    push(JMP, 1'($urandom_range(0, 1)), op, 0);
            ADDI: begin push(AEX, 1'($urandom_range(0, 1)), op, 0); push(AWB, 1'($urandom_range(0, 1)), op, 0); end
            default: t = 1;
        endcase
        if (!t) q[q.size() - 1].last_legal = 1;
    endtask

    task automatic run_n(input int n);
        rec_t r;
        int k = 0;
        while (q.size() > 0 && (n < 0 || k < n)) begin
            r = q.pop_front();
            k++;
            @(negedge clk);
            bus.opcode = r.op;
            bus.mem_ready = r.rdy;
            bus.zero = 1'($urandom_range(0, 1));
            #1;
            chk("state", 64'(state), 64'(r.st));
            chk("ctrl", 64'(obs_out()), 64'(exp_out(r.st, r.rdy, r.op)));
            chk("mem_timeout", 64'(mem_timeout), 64'(exp_to));
`ifdef MULTICYCLE_PERF_CNT_EN
            chk("cycle_count", 64'(cycle_count), 64'(exp_cyc));
            chk("instr_count", 64'(instr_count), 64'(exp_ins));
`else
            chk("cycle_count", 64'(cycle_count), 64'd0);
            chk("instr_count", 64'(instr_count), 64'd0);
`endif
            if (r.st != RST && r.st != HALT) exp_cyc++;
            if (r.last_legal) exp_ins++;
            if (r.trap) exp_to = 1;
        end
    endtask

    task automatic do_reset();
        q.delete();
        @(negedge clk);
        reset = 1'b0;
        bus.mem_ready = 1'b1;
        #1;
        chk("rst_state", 64'(state), 64'(RST));
        chk("rst_ctrl", 64'(obs_out()), 64'd0);
        chk("rst_timeout", 64'(mem_timeout), 64'd0);
        chk("rst_cnt", 64'({cycle_count, instr_count}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rel_state", 64'(state), 64'(RST));
        exp_cyc = 0;
        exp_ins = 0;
        exp_to = 0;
    endtask

    initial begin
        logic [5:0] op;
        logic [5:0] ops[6];
        ops = '{RT, LW, SW, BEQ, J, ADDI};
        bus.opcode = 6'd0;
        bus.zero = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        do_reset();

        add_instr(LW, 0, 0);
        add_instr(BEQ, 0, 0);
        add_instr(BEQ, 0, 0);
        add_instr(RT, 3, 0);
        add_instr(6'b111111, 0, 0);
        add_instr(J, 0, 0);
        add_instr(ADDI, 1, 0);
        add_instr(SW, 0, 2);
        run_n(-1);

        // abort a load while it waits in MEM_RD
        add_instr(LW, 0, 6);
        run_n(5);
        do_reset();

        add_instr(SW, 0, TO);
        run_n(-1);
        do_reset();
        add_instr(SW, 0, TO - 2);
        add_instr(SW, 0, TO - 1);
        add_instr(LW, TO - 1, TO - 1);
        run_n(-1);
        add_instr(RT, TO, 0);
        run_n(-1);
        do_reset();

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                do op = 6'($urandom_range(0, 63)); while (legal(op));
            end else begin
                op = ops[$urandom_range(0, 5)];
            end
            add_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
        end
        run_n(-1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
